// File: rtl/aes_decrypt_top.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, round keys regenerated on the fly
// (forward expansion to K10, then reverse expansion). GF helpers and S-box leaves live here too.

package aes_decrypt_pkg;
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse and maps 0 to 0, as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction
endpackage

module AES_sbox
    import aes_decrypt_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    logic [7:0] b;
    assign b     = gf_inv(in_i);
    assign out_o = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
                   ^ 8'h63;
endmodule

module aes_inv_sbox
    import aes_decrypt_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    logic [7:0] a;
    assign a     = {in_i[6:0], in_i[7]} ^ {in_i[4:0], in_i[7:5]} ^ {in_i[1:0], in_i[7:2]} ^ 8'h05;
    assign out_o = gf_inv(a);
endmodule

module aes_decrypt_top
    import aes_decrypt_pkg::*;
(
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid,
    output logic         AES_busy
);
    typedef enum logic [2:0] {StIdle, StKexp, StAddKey, StRound, StDone} state_e;

    state_e       st_q;
    logic [127:0] state_q, key_q, data_out_q;
    logic [3:0]   cnt_q;
    logic         valid_q, busy_q, rst_done_q;

    // Key schedule: the same four S-boxes serve the forward and the inverse step.
    logic [31:0] a0, a1, a2, a3, b1, b2, b3;
    logic [31:0] sub_src, sub_rot, sub_word, w0;
    logic [127:0] key_fwd, key_inv;

    assign {a0, a1, a2, a3} = key_q;
    assign b3      = a3 ^ a2;
    assign b2      = a2 ^ a1;
    assign b1      = a1 ^ a0;
    assign sub_src = (st_q == StKexp) ? a3 : b3;
    assign sub_rot = {sub_src[23:0], sub_src[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_key_sbox
        AES_sbox u_sbox (
            .in_i  (sub_rot[31 - 8*g -: 8]),
            .out_o (sub_word[31 - 8*g -: 8])
        );
    end

    assign w0      = a0 ^ sub_word ^ {rcon(cnt_q), 24'h0};
    assign key_fwd = {w0, w0 ^ a1, w0 ^ a1 ^ a2, w0 ^ a1 ^ a2 ^ a3};
    assign key_inv = {w0, b1, b2, b3};

    // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
    logic [127:0] sh, isb, ark, mix, round_out;

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int Src = 4 * ((c - r + 4) % 4) + r;
            localparam int Dst = 127 - 8 * (4 * c + r);
            assign sh[Dst -: 8] = state_q[127 - 8*Src -: 8];
            aes_inv_sbox u_inv_sbox (
                .in_i  (sh[Dst -: 8]),
                .out_o (isb[Dst -: 8])
            );
            assign ark[Dst -: 8] = isb[Dst -: 8] ^ key_q[Dst -: 8];
        end

        localparam int Hi = 127 - 32 * c;
        logic [7:0] m0, m1, m2, m3;
        assign {m0, m1, m2, m3} = ark[Hi -: 32];
        assign mix[Hi -: 32] = {
            gf_mul(m0, 8'h0e) ^ gf_mul(m1, 8'h0b) ^ gf_mul(m2, 8'h0d) ^ gf_mul(m3, 8'h09),
            gf_mul(m0, 8'h09) ^ gf_mul(m1, 8'h0e) ^ gf_mul(m2, 8'h0b) ^ gf_mul(m3, 8'h0d),
            gf_mul(m0, 8'h0d) ^ gf_mul(m1, 8'h09) ^ gf_mul(m2, 8'h0e) ^ gf_mul(m3, 8'h0b),
            gf_mul(m0, 8'h0b) ^ gf_mul(m1, 8'h0d) ^ gf_mul(m2, 8'h09) ^ gf_mul(m3, 8'h0e)
        };
    end

    assign round_out = (cnt_q == 4'd0) ? ark : mix;

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            st_q       <= StIdle;
            state_q    <= '0;
            key_q      <= '0;
            data_out_q <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            rst_done_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            valid_q    <= 1'b0;
            unique case (st_q)
                // No capture on the release edge, nor while the valid pulse is showing.
                StIdle: begin
                    if (AES_en && rst_done_q && !valid_q) begin
                        state_q <= AES_data_in;
                        key_q   <= AES_key_in;
                        cnt_q   <= 4'd1;
                        busy_q  <= 1'b1;
                        st_q    <= StKexp;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                StKexp: begin
                    key_q <= key_fwd;
                    if (cnt_q == 4'd10) st_q <= StAddKey;
                    else                cnt_q <= cnt_q + 4'd1;
                end
                StAddKey: begin
                    state_q <= state_q ^ key_q;
                    key_q   <= key_inv;
                    cnt_q   <= 4'd9;
                    st_q    <= StRound;
                end
                StRound: begin
                    state_q <= round_out;
                    key_q   <= key_inv;
                    if (cnt_q == 4'd0) st_q  <= StDone;
                    else               cnt_q <= cnt_q - 4'd1;
                end
                StDone: begin
                    data_out_q <= state_q;
                    valid_q    <= 1'b1;
                    st_q       <= StIdle;
                end
                default: st_q <= StIdle;
            endcase
        end
    end

    assign AES_data_out       = data_out_q;
    assign AES_data_out_valid = valid_q;
    assign AES_busy           = busy_q;
endmodule

// File: tb/tb_aes_decrypt_top.sv
// Bench for aes_decrypt_top: FIPS-197 vectors plus loopback through a table-driven AES-128
// encryption model.

module tb_aes_decrypt_top;
    localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] BKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] BCt   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] BPt   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] ZCt   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [127:0] din = '0;
    logic [127:0] kin = '0;
    logic [127:0] dout;
    logic         valid;
    logic         busy;

    int checks = 0;
    int failures = 0;
    logic [7:0] sbox_t [256];

    aes_decrypt_top dut (
        .AES_clk            (clk),
        .AES_rst_n          (rst_n),
        .AES_en             (en),
        .AES_data_in        (din),
        .AES_key_in         (kin),
        .AES_data_out       (dout),
        .AES_data_out_valid (valid),
        .AES_busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check_blk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (acc[i]) acc = acc ^ (16'h011b << (i - 8));
        return acc[7:0];
    endfunction

    // S-box from its definition: brute-force inverse, then the affine map bit by bit.
    function automatic void build_sbox();
        logic [7:0] inv, s, cst;
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                       ^ inv[(i + 7) % 8] ^ cst[i];
            sbox_t[x] = s;
        end
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, x0, x1, x2, x3;
        logic [31:0]  tmp;
        logic [127:0] out;
        for (int i = 0; i < 4; i++) w[i] = 32'(key >> (96 - 32 * i));
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]],
                       sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int i = 0; i < 16; i++)
            s[i] = 8'(pt >> (120 - 8 * i)) ^ 8'(w[i / 4] >> (24 - 8 * (i % 4)));
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4 * c + r] = t[4 * ((c + r) % 4) + r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    x0 = s[4 * c]; x1 = s[4 * c + 1]; x2 = s[4 * c + 2]; x3 = s[4 * c + 3];
                    s[4 * c]     = gmul(x0, 8'h02) ^ gmul(x1, 8'h03) ^ x2 ^ x3;
                    s[4 * c + 1] = x0 ^ gmul(x1, 8'h02) ^ gmul(x2, 8'h03) ^ x3;
                    s[4 * c + 2] = x0 ^ x1 ^ gmul(x2, 8'h02) ^ gmul(x3, 8'h03);
                    s[4 * c + 3] = gmul(x0, 8'h03) ^ x1 ^ x2 ^ gmul(x3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++)
                s[i] = s[i] ^ 8'(w[4 * rnd + i / 4] >> (24 - 8 * (i % 4)));
        end
        out = '0;
        for (int i = 0; i < 16; i++) out = (out << 8) | 128'(s[i]);
        return out;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One block from idle: capture, 22-edge latency, single-cycle valid, busy throughout.
    task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] key,
                             input logic [127:0] exp, input bit garbage);
        int early;
        early = 0;
        @(negedge clk);
        en = 1'b1; din = ct; kin = key;
        @(posedge clk); #1;
        check_bit({tag, "_busy_at_capture"}, busy, 1'b1);
        en = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk); #1;
            if (k == 1 && garbage) begin din = rand128(); kin = rand128(); end
            if (k < 22 && (valid || !busy)) early++;
        end
        check_int({tag, "_early_valid_or_idle"}, early, 0);
        check_bit({tag, "_valid"}, valid, 1'b1);
        check_bit({tag, "_busy_at_valid"}, busy, 1'b1);
        check_blk({tag, "_data"}, dout, exp);
        @(posedge clk); #1;
        check_bit({tag, "_valid_one_cycle"}, valid, 1'b0);
        check_bit({tag, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        int edges, npulse, p0, p1, bad, nv;
        bit got;
        logic [127:0] pt, key;

        build_sbox();

        // Reset with en already high; release must not capture on its own edge.
        en = 1'b1; din = C1Ct; kin = C1Key;
        repeat (3) @(posedge clk);
        #1;
        check_blk("rst_data", dout, '0);
        check_bit("rst_valid", valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_bit("release_no_capture", busy, 1'b0);
        @(posedge clk); #1;
        check_bit("capture_after_release", busy, 1'b1);
        en = 1'b0;
        edges = 2; got = 1'b0;
        while (!got && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (valid) got = 1'b1;
        end
        check_int("release_latency_edges", edges, 24);
        check_blk("release_c1_data", dout, C1Pt);
        @(posedge clk); #1;

        run_block("c1", C1Ct, C1Key, C1Pt, 1'b0);

        // en held high: two zero blocks with pulses 24 cycles apart.
        @(negedge clk);
        en = 1'b1; din = ZCt; kin = '0;
        npulse = 0; p0 = -1; p1 = -1; bad = 0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (valid) begin
                if (npulse == 0) p0 = n;
                else if (npulse == 1) p1 = n;
                npulse++;
                if (dout !== '0) bad++;
            end
        end
        en = 1'b0;
        check_int("b2b_pulse_count", npulse, 2);
        check_int("b2b_first_pulse", p0, 22);
        check_int("b2b_spacing", p1 - p0, 24);
        check_int("b2b_nonzero_data", bad, 0);
        repeat (40) @(posedge clk);
        #1;

        run_block("fips_b", BCt, BKey, BPt, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check_blk("hold_idle", dout, BPt);

        // Reset at E15 of a C.1 run.
        @(negedge clk);
        en = 1'b1; din = C1Ct; kin = C1Key;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_blk("midrst_data", dout, '0);
        check_bit("midrst_valid", valid, 1'b0);
        check_bit("midrst_busy", busy, 1'b0);
        nv = 0;
        repeat (3) begin @(posedge clk); #1; if (valid) nv++; end
        @(negedge clk); rst_n = 1'b1;
        repeat (30) begin @(posedge clk); #1; if (valid || busy) nv++; end
        check_int("midrst_no_activity", nv, 0);
        run_block("c1_after_rst", C1Ct, C1Key, C1Pt, 1'b0);

        // Loopback through the encryption model.
        pt  = 128'h000000c9000000000000000000000000;
        key = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
        run_block("loop_fixed", aes_enc(pt, key), key, pt, 1'b0);
        for (int v = 0; v < 3; v++) begin
            pt  = rand128();
            key = rand128();
            run_block($sformatf("loop_rand%0d", v), aes_enc(pt, key), key, pt, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
